// File: rtl/clock_set_ctrl_if.sv
// Button inputs and field-select/pulse outputs of the time-set front end.
// The bench drives through master; clock_set_ctrl consumes through slave.
interface clock_set_ctrl_if;
  logic       button1;
  logic       button3;
  logic       button4;
  logic [1:0] tap_out;
  logic       set_mode;
  logic       inc_pulse;
  logic       dec_pulse;

  modport master (
    output button1, button3, button4,
    input  tap_out, set_mode, inc_pulse, dec_pulse
  );

  modport slave (
    input  button1, button3, button4,
    output tap_out, set_mode, inc_pulse, dec_pulse
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-set front end: button sync/debounce, RUN/SEC/MIN/HOUR mode FSM, inc/dec pulses.
// Define AUTO_REPEAT_EN to enable hold-to-repeat on the inc/dec buttons.
module clock_set_ctrl #(
  parameter int unsigned DEB_CYCLES   = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input logic            clk,
  input logic            rst_n,
  clock_set_ctrl_if.slave ctl
);

  localparam int unsigned     DW       = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {RUN = 2'd0, SEC = 2'd1, MIN = 2'd2, HOUR = 2'd3} mode_e;

  // Button index: 0 = mode (button1), 1 = inc (button3), 2 = dec (button4).
  logic [2:0]         raw;
  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         deb_q, deb_d;
  logic [2:0][DW-1:0] cnt_q, cnt_d;
  logic [2:0]         press_q, press_d;
  logic [2:0]         armed_q, armed_d;
  logic [1:0]         vld_q;

  mode_e state_q, state_d;
  logic  set_mode_q, set_mode_d;
  logic  inc_q, inc_d;
  logic  dec_q, dec_d;

  logic mode_stb, inc_stb, dec_stb;

  assign raw = {ctl.button4, ctl.button3, ctl.button1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      cnt_q   <= '0;
      press_q <= '0;
      armed_q <= '0;
      vld_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      armed_q <= armed_d;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  // A button only arms once the synchronizer has real samples showing it released,
  // so a press held through reset never produces a strobe.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = '0;
    press_d = '0;
    armed_d = armed_q;
    for (int b = 0; b < 3; b++) begin
      armed_d[b] = armed_q[b] | (vld_q[1] & sync2_q[b] & deb_q[b]);
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == DEB_LAST) begin
          deb_d[b]   = sync2_q[b];
          press_d[b] = ~sync2_q[b] & armed_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  assign mode_stb = press_q[0];
  assign inc_stb  = press_q[1];
  assign dec_stb  = press_q[2];

`ifdef AUTO_REPEAT_EN
  localparam int unsigned   REP_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned   RW       = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_LAST_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_LAST_NEXT  = RW'(REPEAT_RATE - 1);

  logic          rep_on_q, rep_on_d;
  logic          rep_dec_q, rep_dec_d;
  logic          rep_first_q, rep_first_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          hold_ok;
  logic [RW-1:0] rep_last;

  // Repeats need the own button still held and the opposite one released.
  assign hold_ok  = rep_dec_q ? (~deb_q[2] & deb_q[1]) : (~deb_q[1] & deb_q[2]);
  assign rep_last = rep_first_q ? REP_LAST_FIRST : REP_LAST_NEXT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_on_q    <= 1'b0;
      rep_dec_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      rep_on_q    <= rep_on_d;
      rep_dec_q   <= rep_dec_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end
`else
  // Repeat timing parameters are inert in this build.
  if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_repeat_params_inert
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      set_mode_q <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_mode_q <= set_mode_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
    end
  end

  // inc/dec are single-cycle requests to the counter chain with no back-pressure.
  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_on_d    = rep_on_q;
    rep_dec_d   = rep_dec_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
`endif
    if (mode_stb) begin
      case (state_q)
        RUN:     state_d = SEC;
        SEC:     state_d = MIN;
        MIN:     state_d = HOUR;
        default: state_d = RUN;
      endcase
`ifdef AUTO_REPEAT_EN
      rep_on_d = 1'b0;
`endif
    end else if (state_q != RUN) begin
      if (inc_stb && dec_stb) begin
`ifdef AUTO_REPEAT_EN
        rep_on_d = 1'b0;
`endif
      end else if (inc_stb || dec_stb) begin
        inc_d = inc_stb;
        dec_d = dec_stb;
`ifdef AUTO_REPEAT_EN
        rep_on_d    = 1'b1;
        rep_dec_d   = dec_stb;
        rep_first_d = 1'b1;
        rep_cnt_d   = '0;
      end else if (rep_on_q) begin
        if (!hold_ok) begin
          rep_on_d = 1'b0;
        end else if (rep_cnt_q == rep_last) begin
          inc_d       = ~rep_dec_q;
          dec_d       = rep_dec_q;
          rep_first_d = 1'b0;
          rep_cnt_d   = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
`endif
      end
    end else begin
`ifdef AUTO_REPEAT_EN
      rep_on_d = 1'b0;
`endif
    end
    set_mode_d = (state_d != RUN);
  end

  assign ctl.tap_out   = state_q;
  assign ctl.set_mode  = set_mode_q;
  assign ctl.inc_pulse = inc_q;
  assign ctl.dec_pulse = dec_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl (DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3).
// Pulse and mode-change cycles are logged by a monitor and compared to hand-computed times.
module tb_clock_set_ctrl;

  logic clk;
  logic rst_n;
  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .DEB_CYCLES  (4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: logs the cycle number of every pulse and every tap change
  int         inc_log[$];
  int         dec_log[$];
  int         tap_cyc[$];
  int         tap_val[$];
  logic [1:0] prev_tap = 2'd0;

  always @(posedge clk) begin
    #1;
    if (bus.inc_pulse) inc_log.push_back(cyc);
    if (bus.dec_pulse) dec_log.push_back(cyc);
    if (bus.tap_out !== prev_tap) begin
      tap_cyc.push_back(cyc);
      tap_val.push_back(int'(bus.tap_out));
      prev_tap = bus.tap_out;
    end
  end

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    inc_log.delete();
    dec_log.delete();
    tap_cyc.delete();
    tap_val.delete();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      1:       bus.button1 = v;
      3:       bus.button3 = v;
      default: bus.button4 = v;
    endcase
  endtask

  // drive button low for 'hold' sampled edges; t0 is the first edge that samples it low
  task automatic press(input int b, input int hold, output int t0);
    @(negedge clk);
    set_btn(b, 1'b0);
    t0 = cyc + 1;
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b1);
    repeat (14) @(negedge clk);
  endtask

  function automatic logic [4:0] outs();
    return {bus.tap_out, bus.set_mode, bus.inc_pulse, bus.dec_pulse};
  endfunction

  int t0;
  int t1;

  initial begin
    rst_n       = 1'b0;
    bus.button1 = 1'b1;
    bus.button3 = 1'b1;
    bus.button4 = 1'b1;

    // 1. reset held with buttons toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.button1 = i[0];
      bus.button3 = ~i[0];
      bus.button4 = i[1];
      check("reset_outs", outs(), 5'd0);
    end
    @(negedge clk);
    bus.button1 = 1'b1;
    bus.button3 = 1'b1;
    bus.button4 = 1'b1;
    rst_n = 1'b1;
    clear_logs();
    repeat (10) @(negedge clk);
    check("post_reset_outs", outs(), 5'd0);
    check("post_reset_tap_changes", tap_cyc.size(), 0);

    // 2. mode cycling
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      press(1, 8, t0);
      check("mode_change_count", tap_cyc.size(), 1);
      if (tap_cyc.size() > 0) begin
        check("mode_change_cycle", tap_cyc[0], t0 + 6);
        check("mode_value", tap_val[0], (i + 1) % 4);
      end
      check("set_mode_follows", bus.set_mode, ((i + 1) % 4) != 0);
    end

    // 3. inc in RUN is ignored, inc in SEC pulses once
    clear_logs();
    press(3, 8, t0);
    check("run_no_inc", inc_log.size(), 0);
    press(1, 8, t0);
    check("tap_sec", bus.tap_out, 2'd1);
    clear_logs();
    press(3, 8, t0);
    check("sec_inc_count", inc_log.size(), 1);
    if (inc_log.size() > 0) check("sec_inc_cycle", inc_log[0], t0 + 6);
    check("sec_no_dec", dec_log.size(), 0);

    // 4. bouncing inc button
    clear_logs();
    @(negedge clk); bus.button3 = 1'b0;
    repeat (2) @(negedge clk); bus.button3 = 1'b1;
    @(negedge clk); bus.button3 = 1'b0;
    repeat (3) @(negedge clk); bus.button3 = 1'b1;
    @(negedge clk); bus.button3 = 1'b0;
    t0 = cyc + 1;
    repeat (10) @(negedge clk); bus.button3 = 1'b1;
    repeat (14) @(negedge clk);
    check("bounce_inc_count", inc_log.size(), 1);
    if (inc_log.size() > 0) check("bounce_inc_cycle", inc_log[0], t0 + 6);

    // 5. simultaneous inc+dec in MIN, then mode+dec in SEC
    press(1, 8, t0);
    check("tap_min", bus.tap_out, 2'd2);
    clear_logs();
    @(negedge clk);
    bus.button3 = 1'b0;
    bus.button4 = 1'b0;
    repeat (20) @(negedge clk);
    bus.button3 = 1'b1;
    bus.button4 = 1'b1;
    repeat (14) @(negedge clk);
    check("both_no_inc", inc_log.size(), 0);
    check("both_no_dec", dec_log.size(), 0);
    press(1, 8, t0);
    press(1, 8, t0);
    press(1, 8, t0);
    check("tap_sec_again", bus.tap_out, 2'd1);
    clear_logs();
    @(negedge clk);
    bus.button1 = 1'b0;
    bus.button4 = 1'b0;
    repeat (8) @(negedge clk);
    bus.button1 = 1'b1;
    bus.button4 = 1'b1;
    repeat (14) @(negedge clk);
    check("mode_dec_tap", bus.tap_out, 2'd2);
    check("mode_dec_no_dec", dec_log.size(), 0);

    // 6. held dec in MIN
    clear_logs();
    press(4, 31, t0);
    t1 = t0 + 6;
    exp_q.delete();
    exp_q.push_back(t1);
`ifdef AUTO_REPEAT_EN
    for (int k = 10; k <= 28; k += 3) exp_q.push_back(t1 + k);
`endif
    check("hold_dec_count", dec_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < dec_log.size(); k++)
      check("hold_dec_cycle", dec_log[k], exp_q[k]);
    check("hold_no_inc", inc_log.size(), 0);

    // 7. reset asserted mid-hold, released with buttons still low
    clear_logs();
    @(negedge clk);
    bus.button1 = 1'b0;
    bus.button3 = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_tap", bus.tap_out, 2'd3);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", outs(), 5'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (20) @(negedge clk);
    check("held_through_reset_tap", bus.tap_out, 2'd0);
    check("held_through_reset_changes", tap_cyc.size(), 0);
    check("held_through_reset_inc", inc_log.size(), 0);
    bus.button1 = 1'b1;
    bus.button3 = 1'b1;
    repeat (14) @(negedge clk);
    check("release_no_change", tap_cyc.size(), 0);
    press(1, 8, t0);
    check("repress_change_count", tap_cyc.size(), 1);
    if (tap_cyc.size() > 0) check("repress_change_cycle", tap_cyc[0], t0 + 6);
    check("repress_tap", bus.tap_out, 2'd1);
    press(3, 8, t0);
    check("repress_inc_count", inc_log.size(), 1);
    if (inc_log.size() > 0) check("repress_inc_cycle", inc_log[0], t0 + 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
